// File: rtl/weight_loader_if.sv
// Weight loader bus: weight SRAM read port plus valid/ready MAC weight-register write port.
interface weight_loader_if #(
  parameter int N_MACS = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic [N_MACS-1:0] mac_wr_en;
  logic [DATA_W-1:0] mac_wr_data;
  logic              mac_wr_ready;

  modport master (
    output mem_rd_en, mem_addr, mac_wr_en, mac_wr_data,
    input  mem_rd_data, mac_wr_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, mac_wr_en, mac_wr_data,
    output mem_rd_data, mac_wr_ready
  );
endinterface

// File: rtl/weight_loader.sv
// Weight loader: per load pulse, reads one weight per selected MAC from SRAM and writes it to that MAC.
// Optional running checksum of written weights: define WEIGHT_LOADER_CHECKSUM_EN.
module weight_loader #(
  parameter int N_MACS = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        load,
  input  logic [N_MACS-1:0] weight_ctrl,
  input  logic [ADDR_W-1:0] base_addr,
  weight_loader_if.master   bus,
  output logic              busy,
  output logic              done,
  output logic              load_err,
  output logic [15:0]       checksum
);

  localparam int IDX_W = (N_MACS > 1) ? $clog2(N_MACS) : 1;
  localparam logic [ADDR_W-1:0] GRP_OFFSET = ADDR_W'(N_MACS);

  typedef enum logic [2:0] {IDLE, ISSUE, CAPT, WRITE, DONE} state_t;

  state_t            state, state_nxt;
  logic [N_MACS-1:0] mask;
  logic [ADDR_W-1:0] base;
  logic              grp;
  logic [IDX_W-1:0]  idx, low_idx;
  logic [DATA_W-1:0] data_q;
  logic [N_MACS-1:0] sel, mask_left;
  logic              pulse, accept, xfer;
  logic              unused_load;

  // load[2] is reserved and deliberately ignored.
  assign unused_load = load[2];

  assign pulse     = load[0] | load[1];
  assign accept    = pulse && (state == IDLE);
  assign xfer      = (state == WRITE) && bus.mac_wr_ready;
  assign sel       = {{(N_MACS-1){1'b0}}, 1'b1} << idx;
  assign mask_left = mask & ~sel;
  assign busy      = (state != IDLE);

  // Lowest set bit wins: scan from the top so the lowest match is written last.
  always_comb begin
    low_idx = '0;
    for (int i = N_MACS - 1; i >= 0; i--) begin
      if (mask[i]) low_idx = IDX_W'(i);
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    state_nxt       = state;
    bus.mem_rd_en   = 1'b0;
    bus.mem_addr    = '0;
    bus.mac_wr_en   = '0;
    bus.mac_wr_data = '0;
    done            = 1'b0;
    unique case (state)
      IDLE: if (pulse) state_nxt = (weight_ctrl != '0) ? ISSUE : DONE;
      ISSUE: begin
        bus.mem_rd_en = 1'b1;
        bus.mem_addr  = base + (grp ? GRP_OFFSET : '0) + ADDR_W'(low_idx);
        state_nxt     = CAPT;
      end
      CAPT: state_nxt = WRITE;
      WRITE: begin
        bus.mac_wr_en   = sel;
        bus.mac_wr_data = data_q;
        if (bus.mac_wr_ready) state_nxt = (mask_left != '0) ? ISSUE : DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mask     <= '0;
      base     <= '0;
      grp      <= 1'b0;
      idx      <= '0;
      data_q   <= '0;
      load_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        mask <= weight_ctrl;
        base <= base_addr;
        grp  <= ~load[0];
      end
      if (pulse && state != IDLE) load_err <= 1'b1;
      if (state == ISSUE) idx <= low_idx;
      if (state == CAPT) data_q <= bus.mem_rd_data;
      if (xfer) mask <= mask_left;
    end
  end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         checksum <= '0;
    else if (accept) checksum <= '0;
    else if (xfer)   checksum <= checksum + 16'(data_q);
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader: directed pulses push expected reads/writes/done; a monitor pops and compares.
`timescale 1ns/1ps
module tb_weight_loader;
  localparam int N_MACS = 4;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  load = '0;
  logic [3:0]  weight_ctrl = '0;
  logic [5:0]  base_addr = '0;
  logic        busy, done, load_err;
  logic [15:0] checksum;

  weight_loader_if #(.N_MACS(N_MACS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

  weight_loader #(.N_MACS(N_MACS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .load(load), .weight_ctrl(weight_ctrl), .base_addr(base_addr),
    .bus(bus), .busy(busy), .done(done), .load_err(load_err), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous weight SRAM model: data one cycle after the read strobe.
  logic [7:0] mem [64];
  always @(posedge clk or posedge rst) begin
    if (rst) bus.mem_rd_data <= '0;
    else if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];
  end

  typedef struct { int cyc; logic [5:0] addr; } rd_t;
  typedef struct { int cyc; logic [3:0] en; logic [7:0] data; } wr_t;
  typedef struct { int cyc; logic [15:0] csum; } done_t;
  rd_t   exp_rd[$];
  wr_t   exp_wr[$];
  done_t exp_done[$];
  rd_t   r;
  wr_t   w;
  done_t d;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_checks++;
    $display("FAIL %s: got unexpected 0x%0h at cycle %0d, required none", name, act, cyc);
  endtask

  function automatic logic [15:0] csum(input logic [15:0] s);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    return s;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic exp_read(input int c, input logic [5:0] a);
    exp_rd.push_back('{cyc: c, addr: a});
  endtask
  task automatic exp_write(input int c, input logic [3:0] en, input logic [7:0] dt);
    exp_wr.push_back('{cyc: c, en: en, data: dt});
  endtask
  task automatic exp_fin(input int c, input logic [15:0] s);
    exp_done.push_back('{cyc: c, csum: csum(s)});
  endtask

  // Monitor: samples 1ns after the falling edge, after the driver has updated its inputs.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (bus.mem_rd_en) begin
        if (exp_rd.size() == 0) unexpected("mem_read", 32'(bus.mem_addr));
        else begin
          r = exp_rd.pop_front();
          check("rd_addr", 32'(bus.mem_addr), 32'(r.addr));
          check("rd_cycle", cyc, r.cyc);
        end
      end
      if (bus.mac_wr_en != '0) begin
        check("wr_onehot", 32'($onehot(bus.mac_wr_en)), 1);
        if (bus.mac_wr_ready) begin
          if (exp_wr.size() == 0) unexpected("mac_write", 32'(bus.mac_wr_en));
          else begin
            w = exp_wr.pop_front();
            check("wr_en", 32'(bus.mac_wr_en), 32'(w.en));
            check("wr_data", 32'(bus.mac_wr_data), 32'(w.data));
            check("wr_cycle", cyc, w.cyc);
          end
        end
      end
      if (done) begin
        if (exp_done.size() == 0) unexpected("done", 1);
        else begin
          d = exp_done.pop_front();
          check("done_cycle", cyc, d.cyc);
          check("checksum", 32'(checksum), 32'(d.csum));
        end
      end
    end
  end

  // Called on a falling edge: drives the pulse for one cycle.
  task automatic pulse(input logic [2:0] l, input logic [3:0] c, input logic [5:0] b);
    load = l; weight_ctrl = c; base_addr = b;
    @(negedge clk);
    load = '0; weight_ctrl = '0; base_addr = '0;
  endtask

  task automatic settle(input string name, input int n);
    repeat (n) @(negedge clk);
    check({name, "_pending"}, exp_rd.size() + exp_wr.size() + exp_done.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    foreach (mem[i]) mem[i] = 8'h00;
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h5A; mem[3] = 8'h5C;
    mem[4] = 8'h44; mem[14] = 8'hE4; mem[15] = 8'hF5;
    bus.mac_wr_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_load_err", load_err, 0);
    check("rst_checksum", checksum, 0);
    check("rst_rd_en", bus.mem_rd_en, 0);
    check("rst_wr_en", bus.mac_wr_en, 0);
    rst = 1'b0;
    @(negedge clk);

    // Group 0, two MACs, no stall
    t = cyc;
    exp_read(t + 1, 6'd0); exp_write(t + 3, 4'b0001, 8'h11);
    exp_read(t + 4, 6'd1); exp_write(t + 6, 4'b0010, 8'h22);
    exp_fin(t + 7, 16'h0033);
    pulse(3'b001, 4'b0011, 6'd0);
    settle("grp0", 10);

    // Group 1, MACs 2 and 3, base 8 -> addresses 14, 15
    t = cyc;
    exp_read(t + 1, 6'd14); exp_write(t + 3, 4'b0100, 8'hE4);
    exp_read(t + 4, 6'd15); exp_write(t + 6, 4'b1000, 8'hF5);
    exp_fin(t + 7, 16'h01D9);
    pulse(3'b010, 4'b1100, 6'd8);
    settle("grp1", 10);

    // Ready low for 5 cycles in the first WRITE
    bus.mac_wr_ready = 1'b0;
    t = cyc;
    exp_read(t + 1, 6'd0); exp_write(t + 8, 4'b0001, 8'h11);
    exp_read(t + 9, 6'd1); exp_write(t + 11, 4'b0010, 8'h22);
    exp_fin(t + 12, 16'h0033);
    pulse(3'b001, 4'b0011, 6'd0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("stall_en", bus.mac_wr_en, 4'b0001);
      check("stall_data", bus.mac_wr_data, 8'h11);
      @(negedge clk);
    end
    bus.mac_wr_ready = 1'b1;
    settle("stall", 10);

    // Empty mask: straight to done, busy for one cycle
    t = cyc;
    exp_fin(t + 1, 16'h0000);
    pulse(3'b001, 4'b0000, 6'd5);
    check("empty_busy_t1", busy, 1);
    @(negedge clk);
    check("empty_busy_t2", busy, 0);
    settle("empty", 4);

    // Pulse during ISSUE is ignored and flags load_err
    check("err_before", load_err, 0);
    t = cyc;
    exp_read(t + 1, 6'd3); exp_write(t + 3, 4'b0001, 8'h5C);
    exp_fin(t + 4, 16'h005C);
    pulse(3'b001, 4'b0001, 6'd3);
    pulse(3'b010, 4'b1111, 6'd20);
    settle("busy_pulse", 8);
    check("err_set", load_err, 1);

    // Both pulse bits: group 0 addressing wins
    t = cyc;
    exp_read(t + 1, 6'd4); exp_write(t + 3, 4'b0001, 8'h44);
    exp_fin(t + 4, 16'h0044);
    pulse(3'b011, 4'b0001, 6'd4);
    settle("both_bits", 8);
    check("err_sticky", load_err, 1);

    // Address wrap (62 + 4 + 0 -> 2), then reset in WRITE
    bus.mac_wr_ready = 1'b0;
    t = cyc;
    exp_read(t + 1, 6'd2);
    pulse(3'b010, 4'b0001, 6'd62);
    repeat (2) @(negedge clk);
    check("wrap_wr_en", bus.mac_wr_en, 4'b0001);
    check("wrap_wr_data", bus.mac_wr_data, 8'h5A);
    rst = 1'b1;
    #1;
    check("midrst_wr_en", bus.mac_wr_en, 0);
    check("midrst_busy", busy, 0);
    check("midrst_load_err", load_err, 0);
    check("midrst_checksum", checksum, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.mac_wr_ready = 1'b1;
    settle("post_rst", 8);
    check("post_rst_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
